// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//  - register word offsets (address[3:2])
//  - STATUS bit positions and a helper that packs the STATUS word
//  - transmit FSM state encodings
package uart_tx_mmio_pkg;

  // Register word offsets
  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;
  localparam logic [1:0] UART_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  // Transmit FSM states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic logic [31:0] status_word(input logic ovf, input logic empty,
                                              input logic full, input logic busy);
    logic [31:0] w;
    w             = '0;
    w[STAT_OVF]   = ovf;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_BUSY]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
//  clk, rst_i      clock, async active-high reset
//  push_i, wdata_i write request and byte
//  pop_i           read request; head is rdata_o (valid while !empty_o)
//  full_o, empty_o occupancy flags
//  drop_o          push refused because the FIFO was full and nothing left this edge
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate count.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~do_push;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter sitting beside dram on the CPU data bus.
//  clk, reset   clock, async active-high reset
//  address      CPU data address; window is BASE_ADDR..BASE_ADDR+0xF
//  dram_read    CPU read strobe
//  dram_write   CPU write strobe
//  write_data   CPU store data
//  read_data    register read data (combinational), 0 unless hit & dram_read
//  hit          address falls inside this block's window
//  tx           registered serial output, idle high
//  tx_busy      frame in progress or bytes still queued
// Registers: 0x0 TXDATA (W push), 0x4 STATUS {ovf,empty,full,busy} (W bit3 clears ovf),
//            0x8 BAUDDIV [15:0], 0xC reserved.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        dram_read,
  input  logic        dram_write,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy
);

  logic [1:0]  off;
  logic        wr_en, push, pop;
  logic [7:0]  fifo_head;
  logic        full, empty, drop;
  logic [31:0] rd_mux;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic [15:0] div_q;
  logic        ovf_q;
  logic        bit_end;

  logic unused_bits;
  assign unused_bits = ^{address[1:0], write_data[31:16]};

  // ---------------- decode ----------------
  assign hit   = (address[31:4] == BASE_ADDR[31:4]);
  assign off   = address[3:2];
  assign wr_en = hit & dram_write;
  assign push  = wr_en & (off == UART_TXDATA);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (write_data[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (full),
    .empty_o (empty),
    .drop_o  (drop)
  );

  assign tx_busy = (state_q != S_IDLE) | ~empty;
  assign tx      = tx_q;

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en && off == UART_BAUDDIV) div_q <= write_data[15:0];
      // drop and clear come from different offsets, never the same edge
      if (drop)                                           ovf_q <= 1'b1;
      else if (wr_en && off == UART_STATUS && write_data[3]) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      UART_STATUS:  rd_mux = status_word(ovf_q, empty, full, tx_busy);
      UART_BAUDDIV: rd_mux = {16'b0, div_q};
      default:      rd_mux = '0;
    endcase
    read_data = (hit & dram_read) ? rd_mux : '0;
  end

  // ---------------- transmit FSM ----------------
  // Every bit period reloads the counter from div_q, so a BAUDDIV write only
  // affects the period that starts after it.
  assign bit_end = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = div_q;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = div_q;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            // back-to-back: next start bit follows the stop bit directly
            pop     = 1'b1;
            shift_d = fifo_head;
            cnt_d   = div_q;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        dram_read, dram_write;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit, tx, tx_busy;

  uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
    .clk(clk), .reset(reset), .address(address), .dram_read(dram_read),
    .dram_write(dram_write), .write_data(write_data), .read_data(read_data),
    .hit(hit), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      data;
    logic [9:0][7:0] len;   // cycles per bit period: [0]=start, [1..8]=data, [9]=stop
    logic            b2b;   // next frame must start the cycle after the stop bit
    logic            abort; // frame is expected to be cut short by reset
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;
  bit mon_busy = 0;

  function automatic frame_t uni(input logic [7:0] d, input int p,
                                 input logic b2b, input logic ab);
    frame_t f;
    f.data = d;
    for (int i = 0; i < 10; i++) f.len[i] = 8'(p);
    f.b2b   = b2b;
    f.abort = ab;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    address = BASE + {24'b0, a}; write_data = d; dram_write = 1'b1;
    @(negedge clk);
    dram_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] want,
                        input logic want_hit);
    @(negedge clk);
    address = a; dram_read = 1'b1;
    #1;
    chk({nm, "_data"}, read_data, want);
    chk({nm, "_hit"}, {31'b0, hit}, {31'b0, want_hit});
    dram_read = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max);
    int n = 0;
    while (tx_busy === 1'b1 && n < max) begin @(negedge clk); n++; end
    if (n >= max) begin
      total++; bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", nm, n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes tx and compares each frame against the scoreboard queue.
  initial begin : monitor
    frame_t e;
    logic   prev, lv;
    bit     more, ab, err;
    int     errbit;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) prev = 1'b1;
      else if (prev && !tx) begin
        mon_busy = 1;
        more = 1;
        while (more) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got start bit at %0t, required no frame", $time);
            more = 0;
          end else begin
            e = exp_q.pop_front();
            err = 0; ab = 0; errbit = -1;
            for (int b = 0; b < 10 && !ab; b++) begin
              lv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
              for (int c = (b == 0) ? 1 : 0; c < int'(e.len[b]) && !ab; c++) begin
                @(negedge clk);
                if (reset) ab = 1;
                else if (tx !== lv) begin
                  if (!err) errbit = b;
                  err = 1;
                end
              end
            end
            total++;
            if (err || (ab != e.abort)) begin
              bad++;
              $display("FAIL frame_%h: got first bad period %0d aborted=%0d, required clean aborted=%0d",
                       e.data, errbit, ab, e.abort);
            end
            if (e.b2b && !ab) begin
              @(negedge clk);
              total++;
              if (reset || tx !== 1'b0) begin
                bad++;
                $display("FAIL b2b_gap_%h: got tx=%b after stop, required start bit 0", e.data, tx);
              end
              more = !reset && (tx === 1'b0);
            end else more = 0;
          end
        end
        prev = tx;
        mon_busy = 0;
      end else prev = tx;
    end
  end

  initial begin : stim
    int n;
    frame_t f;
    reset = 1'b1; address = '0; dram_read = 1'b0; dram_write = 1'b0; write_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state and decode
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    rd_chk("rst_status", BASE + 32'h4, 32'h4, 1'b1);
    rd_chk("rst_bauddiv", BASE + 32'h8, 32'd867, 1'b1);
    rd_chk("rd_txdata", BASE + 32'h0, 32'h0, 1'b1);
    rd_chk("rd_rsvd", BASE + 32'hC, 32'h0, 1'b1);
    rd_chk("rd_outside", BASE + 32'h20, 32'h0, 1'b0);
    @(negedge clk); address = BASE + 32'h8; dram_read = 1'b0; #1;
    chk("no_read_strobe", read_data, 32'h0);

    // 1: single frame, 4 cycles per bit
    wr(8'h8, 32'd3);
    exp_q.push_back(uni(8'h55, 4, 1'b0, 1'b0));
    wr(8'h0, 32'h55);
    chk("t1_tx_before_start", {31'b0, tx}, 32'd1);
    @(negedge clk);
    chk("t1_first_fall", {31'b0, tx}, 32'd0);
    n = 0;
    while (tx_busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("t1_busy_cycles", n, 32'd40);
    wait_idle("t1", 100);

    // 2: 1 cycle per bit, back-to-back frames
    wr(8'h8, 32'd0);
    exp_q.push_back(uni(8'hA5, 1, 1'b1, 1'b0));
    exp_q.push_back(uni(8'h3C, 1, 1'b0, 1'b0));
    wr(8'h0, 32'hA5);
    wr(8'h0, 32'h3C);
    wait_idle("t2", 200);
    rd_chk("t2_status", BASE + 32'h4, 32'h4, 1'b1);

    // 3: overflow with a stalled transmitter
    wr(8'h8, 32'd100);
    for (int i = 0; i < 9; i++)
      exp_q.push_back(uni(8'h10 + 8'(i), 101, (i < 8) ? 1'b1 : 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) wr(8'h0, 32'h10 + i);
    rd_chk("t3_status_ovf", BASE + 32'h4, 32'hB, 1'b1);
    wr(8'h4, 32'h8);
    rd_chk("t3_status_clr", BASE + 32'h4, 32'h3, 1'b1);
    wait_idle("t3", 12000);
    rd_chk("t3_status_end", BASE + 32'h4, 32'h4, 1'b1);

    // 6: divisor change during data bit 2
    wr(8'h8, 32'd3);
    f = uni(8'h55, 4, 1'b0, 1'b0);
    for (int i = 4; i < 10; i++) f.len[i] = 8'd8;
    exp_q.push_back(f);
    wr(8'h0, 32'h55);
    repeat (14) @(posedge clk);
    wr(8'h8, 32'd7);
    wait_idle("t6", 300);
    rd_chk("t6_bauddiv", BASE + 32'h8, 32'd7, 1'b1);

    // 5: reset during data bit 3
    wr(8'h8, 32'd3);
    exp_q.push_back(uni(8'hF0, 4, 1'b0, 1'b1));
    wr(8'h0, 32'hF0);
    repeat (18) @(posedge clk);
    #1 chk("t5_bit3_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    #1 chk("t5_tx_async", {31'b0, tx}, 32'd1);
    chk("t5_busy_async", {31'b0, tx_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd_chk("t5_status", BASE + 32'h4, 32'h4, 1'b1);
    rd_chk("t5_bauddiv", BASE + 32'h8, 32'd867, 1'b1);
    wr(8'hC, 32'h1234);
    rd_chk("t5_rsvd_ignored", BASE + 32'h8, 32'd867, 1'b1);
    repeat (60) @(negedge clk);
    chk("t5_idle_tx", {31'b0, tx}, 32'd1);

    chk("frames_pending", exp_q.size(), 32'd0);
    chk("monitor_idle", {31'b0, mon_busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
